arnold_clkgen: RTL and testbench
================================

ARNOLD_CLKGEN -- requirements
Module: arnold_clkgen

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16: width of the half-period divider value.
REQ-002 SHALL have parameter RST_LEN_WIDTH, default 8: width of the reset-length value.
REQ-003 SHALL have parameter CNT_WIDTH, default 32: width of the cycle counter.
REQ-004 SHALL have port clk_48mhz_i, input, 1: the single block clock.
REQ-005 SHALL have port reset_i, input, 1: reset, synchronous to clk_48mhz_i, active-high.
REQ-006 SHALL have port cfg_en_i, input, 1: output clock enable.
REQ-007 SHALL have port cfg_div_i, input, DIV_WIDTH: half-period in clk_48mhz_i cycles, minus 1.
REQ-008 SHALL have port cfg_rst_len_i, input, RST_LEN_WIDTH: reset hold, in arnold_clk periods, minus 1.
REQ-009 SHALL have port rst_req_i, input, 1: one-cycle software reset request.
REQ-010 SHALL have port arnold_clk_o, output, 1: registered divided clock to the Arnold core.
REQ-011 SHALL have port arnold_rst_o, output, 1: registered active-high reset to the Arnold core.
REQ-012 SHALL have port busy_o, output, 1: high while the reset sequence is in progress.
REQ-013 SHALL have port cycle_cnt_o, output, CNT_WIDTH: number of arnold_clk rising edges since reset release.

Function
REQ-014 SHALL toggle arnold_clk_o when the phase counter reaches div_q, then clear the counter; each half-period therefore lasts div_q+1 cycles.
REQ-015 SHALL load div_q from cfg_div_i at every toggle, so a changed cfg_div_i applies from the next half-period and never produces a runt pulse.
REQ-016 cfg_div_i=0 SHALL yield 24 MHz (toggle every cycle).
REQ-017 When cfg_en_i is low and arnold_clk_o is high, the block SHALL complete the current high phase and then hold arnold_clk_o low.
REQ-018 While cfg_en_i is low and arnold_clk_o is low, the phase counter SHALL be held at 0.
REQ-019 After re-enable, the first rising edge SHALL occur cfg_div_i+1 cycles later.
REQ-020 The FSM SHALL have states S_RST and S_RUN; arnold_rst_o=1 and busy_o=1 exactly in S_RST.
REQ-021 On entry to S_RST, the block SHALL latch cfg_rst_len_i into len_q and clear rst_cnt.
REQ-022 In S_RST, rst_cnt SHALL increment on each rising toggle of arnold_clk_o.
REQ-023 When rst_cnt equals len_q+1, the FSM SHALL move to S_RUN on the next falling toggle; arnold_rst_o drops in the same cycle arnold_clk_o goes low.
REQ-024 rst_req_i in S_RUN SHALL move the FSM to S_RST on the next cycle.
REQ-025 rst_req_i in S_RST SHALL clear rst_cnt and re-latch len_q (restart).
REQ-026 When the clock is disabled in S_RST, counting SHALL stall and arnold_rst_o SHALL stay high.
REQ-027 cycle_cnt SHALL clear on entry to S_RST, increment on each rising toggle in S_RUN, and wrap from all-ones to 0.
REQ-028 rst_req_i coinciding with the S_RST-to-S_RUN transition SHALL win: the FSM stays in S_RST and restarts.

Reset
REQ-029 reset_i SHALL have priority over all other inputs.
REQ-030 Reset values SHALL be: arnold_clk_o=0, arnold_rst_o=1, busy_o=1, cycle_cnt_o=0, state S_RST, phase counter 0, rst_cnt 0, div_q=cfg_div_i, len_q=cfg_rst_len_i.
REQ-031 After reset_i deasserts, the power-on reset sequence SHALL run exactly as a rst_req_i sequence.

Configuration
REQ-032 With ARNOLD_CLKGEN_CYCLE_CNT_EN defined, the cycle counter SHALL be built and SHALL behave per REQ-027.
REQ-033 Without ARNOLD_CLKGEN_CYCLE_CNT_EN, cycle_cnt_o SHALL be tied to 0 and no counter flops SHALL be built.

Structure
REQ-034 Package arnold_pkg SHALL hold the FSM state enum (S_RST, S_RUN) and the default widths DIV_WIDTH, RST_LEN_WIDTH and CNT_WIDTH.
REQ-035 The divider (phase counter, div_q, enable gating, rise/fall toggle strobes) SHALL be sub-module arnold_clk_div.
REQ-036 The FSM and cycle counter SHALL reside in arnold_clkgen.

Verification
REQ-037 Reset then cfg_en_i=1, cfg_div_i=1, cfg_rst_len_i=3 -> arnold_clk_o period 4 cycles (12 MHz); arnold_rst_o falls at the falling toggle after the 4th rising edge; busy_o falls with it.
REQ-038 cfg_div_i changed 1->4 while arnold_clk_o is high -> current high phase lasts 2 cycles; next phases last 5 cycles; no pulse shorter than 2 cycles.
REQ-039 cfg_en_i=0 one cycle into a high phase with cfg_div_i=3 -> high phase completes at 4 cycles, then arnold_clk_o stays low; re-enable -> rising edge 4 cycles later.
REQ-040 In S_RUN after 10 rising edges, pulse rst_req_i -> cycle_cnt_o=10 before the pulse, 0 one cycle after, and arnold_rst_o=1 one cycle after.
REQ-041 rst_req_i pulsed on the 3rd rising edge of a 4-period reset -> reset held for a further 4 full periods.
REQ-042 With the macro defined, cycle_cnt forced near wrap (CNT_WIDTH=4, 15 edges) -> the next edge gives 0; with the macro undefined -> cycle_cnt_o stays 0 throughout.

Source files
------------

// File: rtl/arnold_pkg.sv
// Shared types and default widths for the Arnold clock/reset generator.
package arnold_pkg;

  localparam int DIV_WIDTH     = 16;
  localparam int RST_LEN_WIDTH = 8;
  localparam int CNT_WIDTH     = 32;

  // Encoded so that the state flop itself is the active-high core reset.
  typedef enum logic {
    S_RUN = 1'b0,
    S_RST = 1'b1
  } state_e;

endpackage

// File: rtl/arnold_clk_div.sv
// Programmable divider producing the registered Arnold clock plus
// single-cycle strobes flagging the rising/falling toggle about to happen.
module arnold_clk_div #(
  parameter int DIV_WIDTH = arnold_pkg::DIV_WIDTH
) (
  input  logic                 clk_48mhz_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 clk_o,
  output logic                 rise_o,
  output logic                 fall_o
);

  logic [DIV_WIDTH-1:0] phase_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 hold;
  logic                 hit;

  // A disable only takes effect once the output is low, so a high phase is
  // never cut short.
  assign hold   = !en_i && !clk_o;
  assign hit    = !hold && (phase_q == div_q);
  assign rise_o = hit && !clk_o;
  assign fall_o = hit && clk_o;

  always_ff @(posedge clk_48mhz_i) begin
    if (reset_i) begin
      clk_o   <= 1'b0;
      phase_q <= '0;
      div_q   <= div_i;
    end else if (hold) begin
      phase_q <= '0;
      div_q   <= div_i;
    end else if (hit) begin
      // Divider changes land only on a toggle boundary: no runt pulses.
      clk_o   <= ~clk_o;
      phase_q <= '0;
      div_q   <= div_i;
    end else begin
      phase_q <= phase_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/arnold_clkgen.sv
// Arnold core clock and reset sequencer. Define ARNOLD_CLKGEN_CYCLE_CNT_EN to
// build the rising-edge cycle counter; otherwise cycle_cnt_o is tied to 0.
module arnold_clkgen
  import arnold_pkg::state_e;
  import arnold_pkg::S_RST;
  import arnold_pkg::S_RUN;
#(
  parameter int DIV_WIDTH     = arnold_pkg::DIV_WIDTH,
  parameter int RST_LEN_WIDTH = arnold_pkg::RST_LEN_WIDTH,
  parameter int CNT_WIDTH     = arnold_pkg::CNT_WIDTH
) (
  input  logic                     clk_48mhz_i,
  input  logic                     reset_i,
  input  logic                     cfg_en_i,
  input  logic [DIV_WIDTH-1:0]     cfg_div_i,
  input  logic [RST_LEN_WIDTH-1:0] cfg_rst_len_i,
  input  logic                     rst_req_i,
  output logic                     arnold_clk_o,
  output logic                     arnold_rst_o,
  output logic                     busy_o,
  output logic [CNT_WIDTH-1:0]     cycle_cnt_o
);

  state_e                   state_q;
  state_e                   state_d;
  logic [RST_LEN_WIDTH:0]   rst_cnt_q;
  logic [RST_LEN_WIDTH-1:0] len_q;
  logic [RST_LEN_WIDTH:0]   len_end;
  logic                     rst_clr;
  logic                     rst_inc;
  logic                     rise;
  logic                     fall;

  arnold_clk_div #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clk_div (
    .clk_48mhz_i (clk_48mhz_i),
    .reset_i     (reset_i),
    .en_i        (cfg_en_i),
    .div_i       (cfg_div_i),
    .clk_o       (arnold_clk_o),
    .rise_o      (rise),
    .fall_o      (fall)
  );

  // One extra bit so len_q+1 never wraps.
  assign len_end = {1'b0, len_q} + (RST_LEN_WIDTH + 1)'(1);

  always_comb begin
    state_d = state_q;
    rst_clr = 1'b0;
    rst_inc = 1'b0;
    case (state_q)
      S_RUN: begin
        if (rst_req_i) begin
          state_d = S_RST;
          rst_clr = 1'b1;
        end
      end
      S_RST: begin
        // A request always restarts, even on the cycle that would release.
        if (rst_req_i) begin
          rst_clr = 1'b1;
        end else if (rise) begin
          rst_inc = 1'b1;
        end else if (fall && (rst_cnt_q == len_end)) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RST;
        rst_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz_i) begin
    if (reset_i) begin
      state_q   <= S_RST;
      rst_cnt_q <= '0;
      len_q     <= cfg_rst_len_i;
    end else begin
      state_q <= state_d;
      if (rst_clr) begin
        rst_cnt_q <= '0;
        len_q     <= cfg_rst_len_i;
      end else if (rst_inc) begin
        rst_cnt_q <= rst_cnt_q + (RST_LEN_WIDTH + 1)'(1);
      end
    end
  end

  assign arnold_rst_o = (state_q == S_RST);
  assign busy_o       = (state_q == S_RST);

`ifdef ARNOLD_CLKGEN_CYCLE_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_cnt_q;

  always_ff @(posedge clk_48mhz_i) begin
    if (reset_i) begin
      cycle_cnt_q <= '0;
    end else if (state_d == S_RST) begin
      cycle_cnt_q <= '0;
    end else if ((state_q == S_RUN) && rise) begin
      cycle_cnt_q <= cycle_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
`else
  assign cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_arnold_clkgen.sv
// Directed bench for arnold_clkgen: expected per-cycle output values are
// queued with their cycle number and compared when that cycle is sampled.
module tb_arnold_clkgen;

  localparam int DIV_WIDTH     = 16;
  localparam int RST_LEN_WIDTH = 8;
  localparam int CNT_WIDTH     = 4;
  localparam int W             = 40;

  localparam int SEL_CLK  = 0;
  localparam int SEL_RST  = 1;
  localparam int SEL_BUSY = 2;
  localparam int SEL_CNT  = 3;

  logic                     clk_48mhz_i = 1'b0;
  logic                     reset_i;
  logic                     cfg_en_i;
  logic [DIV_WIDTH-1:0]     cfg_div_i;
  logic [RST_LEN_WIDTH-1:0] cfg_rst_len_i;
  logic                     rst_req_i;
  logic                     arnold_clk_o;
  logic                     arnold_rst_o;
  logic                     busy_o;
  logic [CNT_WIDTH-1:0]     cycle_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  // Entry layout: {cycle[31:0], selector[3:0], value[3:0]}
  logic [W-1:0] exp_q[$];
  string sel_name [4] = '{"clk", "rst", "busy", "cnt"};

  // ---------------- clock / reset ----------------
  always #5 clk_48mhz_i = ~clk_48mhz_i;

  arnold_clkgen #(
    .DIV_WIDTH     (DIV_WIDTH),
    .RST_LEN_WIDTH (RST_LEN_WIDTH),
    .CNT_WIDTH     (CNT_WIDTH)
  ) dut (
    .clk_48mhz_i   (clk_48mhz_i),
    .reset_i       (reset_i),
    .cfg_en_i      (cfg_en_i),
    .cfg_div_i     (cfg_div_i),
    .cfg_rst_len_i (cfg_rst_len_i),
    .rst_req_i     (rst_req_i),
    .arnold_clk_o  (arnold_clk_o),
    .arnold_rst_o  (arnold_rst_o),
    .busy_o        (busy_o),
    .cycle_cnt_o   (cycle_cnt_o)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc - t0, obs, want);
    end
  endtask

  function automatic logic [3:0] exp_cnt(input int n);
`ifdef ARNOLD_CLKGEN_CYCLE_CNT_EN
    return 4'(n % 16);
`else
    return 4'(n * 0);
`endif
  endfunction

  function automatic logic [3:0] observe(input logic [3:0] sel);
    case (sel)
      4'(SEL_CLK):  return {3'b000, arnold_clk_o};
      4'(SEL_RST):  return {3'b000, arnold_rst_o};
      4'(SEL_BUSY): return {3'b000, busy_o};
      default:      return cycle_cnt_o;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic expect_at(input int dc, input int sel, input logic [3:0] val);
    exp_q.push_back({32'(t0 + dc), 4'(sel), val});
  endtask

  // Advance one clock, sample 1 time unit after the edge, retire due entries.
  task automatic tick();
    @(posedge clk_48mhz_i);
    #1;
    cyc++;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      logic [W-1:0] e;
      e = exp_q[i];
      if (e[39:8] == 32'(cyc)) begin
        check(sel_name[e[5:4]], {28'd0, observe(e[7:4])}, {28'd0, e[3:0]});
        exp_q.delete(i);
      end
    end
  endtask

  task automatic run_to(input int dc);
    while (cyc < t0 + dc) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_i       = 1'b1;
    cfg_en_i      = 1'b1;
    cfg_div_i     = 16'd1;
    cfg_rst_len_i = 8'd3;
    rst_req_i     = 1'b0;
    repeat ($urandom_range(2, 5)) tick();

    check("reset_clk",  {31'd0, arnold_clk_o}, 32'd0);
    check("reset_rst",  {31'd0, arnold_rst_o}, 32'd1);
    check("reset_busy", {31'd0, busy_o},       32'd1);
    check("reset_cnt",  {28'd0, cycle_cnt_o},  32'd0);

    // Power-on sequence: 12 MHz clock, reset held for 4 rising edges.
    reset_i = 1'b0;
    t0 = cyc;
    expect_at(1,  SEL_CLK, 4'd0);
    expect_at(2,  SEL_CLK, 4'd1);
    expect_at(3,  SEL_CLK, 4'd1);
    expect_at(4,  SEL_CLK, 4'd0);
    expect_at(6,  SEL_CLK, 4'd1);
    expect_at(14, SEL_CLK, 4'd1);
    expect_at(14, SEL_CNT, 4'd0);
    expect_at(15, SEL_RST, 4'd1);
    expect_at(15, SEL_BUSY, 4'd1);
    expect_at(16, SEL_RST, 4'd0);
    expect_at(16, SEL_BUSY, 4'd0);
    expect_at(16, SEL_CLK, 4'd0);
    expect_at(54, SEL_CNT, exp_cnt(10));
    expect_at(74, SEL_CNT, exp_cnt(15));
    expect_at(78, SEL_CNT, exp_cnt(16));
    expect_at(82, SEL_CNT, exp_cnt(17));
    run_to(82);

    // Software reset, then a restart on the 3rd rising edge.
    expect_at(83,  SEL_RST, 4'd1);
    expect_at(83,  SEL_BUSY, 4'd1);
    expect_at(83,  SEL_CNT, 4'd0);
    expect_at(100, SEL_RST, 4'd1);
    expect_at(110, SEL_CLK, 4'd1);
    expect_at(111, SEL_RST, 4'd1);
    expect_at(112, SEL_RST, 4'd0);
    expect_at(112, SEL_BUSY, 4'd0);
    expect_at(112, SEL_CLK, 4'd0);
    rst_req_i = 1'b1;
    tick();
    rst_req_i = 1'b0;
    run_to(93);
    rst_req_i = 1'b1;
    tick();
    rst_req_i = 1'b0;

    // Ten edges in run, then a request clears the counter next cycle.
    expect_at(150, SEL_CNT, exp_cnt(10));
    expect_at(150, SEL_RST, 4'd0);
    expect_at(151, SEL_CNT, 4'd0);
    expect_at(151, SEL_RST, 4'd1);
    expect_at(151, SEL_BUSY, 4'd1);
    run_to(150);
    rst_req_i = 1'b1;
    tick();
    rst_req_i = 1'b0;

    // Request coinciding with the release falling toggle wins.
    expect_at(168, SEL_RST, 4'd1);
    expect_at(168, SEL_CLK, 4'd0);
    expect_at(183, SEL_RST, 4'd1);
    expect_at(184, SEL_RST, 4'd0);
    expect_at(184, SEL_CLK, 4'd0);
    run_to(167);
    rst_req_i = 1'b1;
    tick();
    rst_req_i = 1'b0;

    // Divider 1 -> 4 during a high phase.
    expect_at(186, SEL_CNT, exp_cnt(1));
    expect_at(187, SEL_CLK, 4'd1);
    expect_at(188, SEL_CLK, 4'd0);
    expect_at(192, SEL_CLK, 4'd0);
    expect_at(193, SEL_CLK, 4'd1);
    expect_at(197, SEL_CLK, 4'd1);
    expect_at(198, SEL_CLK, 4'd0);
    run_to(186);
    cfg_div_i = 16'd4;

    // Divider 3, disable one cycle into the high phase, then re-enable.
    run_to(198);
    cfg_div_i = 16'd3;
    expect_at(203, SEL_CLK, 4'd1);
    expect_at(206, SEL_CLK, 4'd1);
    expect_at(207, SEL_CLK, 4'd0);
    expect_at(215, SEL_CLK, 4'd0);
    expect_at(220, SEL_CLK, 4'd0);
    run_to(204);
    cfg_en_i = 1'b0;
    run_to(220);
    cfg_en_i = 1'b1;
    expect_at(223, SEL_CLK, 4'd0);
    expect_at(224, SEL_CLK, 4'd1);
    run_to(224);

    // Disabled clock during reset stalls the sequence.
    expect_at(225, SEL_RST, 4'd1);
    expect_at(260, SEL_RST, 4'd1);
    expect_at(260, SEL_BUSY, 4'd1);
    expect_at(260, SEL_CLK, 4'd0);
    rst_req_i = 1'b1;
    tick();
    rst_req_i = 1'b0;
    cfg_en_i  = 1'b0;
    run_to(260);
    cfg_en_i = 1'b1;
    expect_at(264, SEL_CLK, 4'd1);
    expect_at(288, SEL_CLK, 4'd1);
    expect_at(291, SEL_RST, 4'd1);
    expect_at(292, SEL_RST, 4'd0);
    expect_at(292, SEL_BUSY, 4'd0);
    expect_at(296, SEL_CLK, 4'd1);
    expect_at(296, SEL_CNT, exp_cnt(1));
    run_to(300);

    // ---------------- final report ----------------
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
